// File: rtl/bomb_round_ctrl.sv
// Multi-round game sequencer for the bomb dismantlement game: load/show password, timed entry, win/lose.
// Optional feature macro PENALTY_EN: a wrong entry also deducts PENALTY_SEC seconds from the countdown.
module bomb_round_ctrl #(
  parameter int PSW_W       = 7,
  parameter int TICK_DIV    = 1000,
  parameter int SHOW_SEC    = 3,
  parameter int CNT_SEC     = 20,
  parameter int MAX_TRIES   = 3,
  parameter int ROUNDS      = 3,
  parameter int FACE_SEC    = 2,
  parameter int PENALTY_SEC = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             arm,
  input  logic                             load,
  input  logic                             enter,
  input  logic [PSW_W-1:0]                 sw,
  input  logic [PSW_W-1:0]                 psw,
  output logic                             psw_load,
  output logic                             show,
  output logic                             counting,
  output logic [PSW_W-1:0]                 ld,
  output logic [$clog2(CNT_SEC+1)-1:0]     sec_left,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [$clog2(ROUNDS+1)-1:0]      round,
  output logic                             win,
  output logic                             lose,
  output logic                             beep,
  output logic                             done
);

  localparam int SEC_W  = $clog2(CNT_SEC+1);
  localparam int TRY_W  = $clog2(MAX_TRIES+1);
  localparam int RND_W  = $clog2(ROUNDS+1);
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (SHOW_SEC > FACE_SEC) ? SHOW_SEC : FACE_SEC;
  localparam int PH_W   = $clog2(PH_MAX+1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHOW  = 3'd2,
    INPUT = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               lph_q, lph_d;
  logic [PSW_W-1:0]   psw_q, psw_d;
  logic [SEC_W-1:0]   sec_left_q, sec_left_d;
  logic [TRY_W-1:0]   tries_left_q, tries_left_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               psw_load_q, psw_load_d;
  logic               show_q, show_d;
  logic               counting_q, counting_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               beep_q, beep_d;
  logic               done_q, done_d;

  logic tick;
  logic match;

  assign tick  = (div_q == DIV_W'(TICK_DIV-1));
  assign match = (sw == psw_q);

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    ph_d         = ph_q;
    lph_d        = lph_q;
    psw_d        = psw_q;
    sec_left_d   = sec_left_q;
    tries_left_d = tries_left_q;
    round_d      = round_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (arm && load) begin
          state_d = LOAD;
          round_d = '0;
        end
      end
      LOAD: begin
        // cycle 0 requests the password, cycle 1 captures it
        if (!lph_q) begin
          lph_d = 1'b1;
        end else begin
          psw_d   = psw;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (tick) begin
          if (ph_q == PH_W'(SHOW_SEC-1)) state_d = INPUT;
          else                           ph_d    = ph_q + PH_W'(1);
        end
      end
      INPUT: begin
        if (enter && match) begin
          // a correct entry beats a same-cycle timeout tick
          if (round_q < RND_W'(ROUNDS-1)) begin
            round_d = round_q + RND_W'(1);
            state_d = LOAD;
          end else begin
            state_d = WIN;
          end
        end else if (enter) begin
          tries_left_d = tries_left_q - TRY_W'(1);
          if (tries_left_q == TRY_W'(1)) state_d = LOSE;
`ifdef PENALTY_EN
          if (int'(sec_left_q) > PENALTY_SEC) begin
            sec_left_d = sec_left_q - SEC_W'(PENALTY_SEC);
          end else begin
            sec_left_d = '0;
            state_d    = LOSE;
          end
`else
          if (tick) begin
            sec_left_d = sec_left_q - SEC_W'(1);
            if (sec_left_q == SEC_W'(1)) state_d = LOSE;
          end
`endif
        end else if (tick) begin
          sec_left_d = sec_left_q - SEC_W'(1);
          if (sec_left_q == SEC_W'(1)) state_d = LOSE;
        end
      end
      WIN, LOSE: begin
        if (tick) begin
          if (ph_q == PH_W'(FACE_SEC-1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // disarming aborts silently from anywhere in a game
    if (state_q != IDLE && !arm) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end

    if (state_d != state_q) begin
      div_d = '0;
      ph_d  = '0;
      lph_d = 1'b0;
      if (state_d == INPUT) begin
        sec_left_d   = SEC_W'(CNT_SEC);
        tries_left_d = TRY_W'(MAX_TRIES);
      end
      if (state_d == IDLE) begin
        sec_left_d   = '0;
        tries_left_d = '0;
        round_d      = '0;
        psw_d        = '0;
      end
    end

    psw_load_d = (state_d == LOAD) && (state_q != LOAD);
    show_d     = (state_d == SHOW);
    counting_d = (state_d == INPUT);
    win_d      = (state_d == WIN);
    lose_d     = (state_d == LOSE);
    beep_d     = (state_d == WIN) || (state_d == LOSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      ph_q         <= '0;
      lph_q        <= 1'b0;
      psw_q        <= '0;
      sec_left_q   <= '0;
      tries_left_q <= '0;
      round_q      <= '0;
      psw_load_q   <= 1'b0;
      show_q       <= 1'b0;
      counting_q   <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      beep_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      ph_q         <= ph_d;
      lph_q        <= lph_d;
      psw_q        <= psw_d;
      sec_left_q   <= sec_left_d;
      tries_left_q <= tries_left_d;
      round_q      <= round_d;
      psw_load_q   <= psw_load_d;
      show_q       <= show_d;
      counting_q   <= counting_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      beep_q       <= beep_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    ld = '0;
    if (show_q)          ld = psw_q;
    else if (counting_q) ld = sw;
  end

  assign psw_load   = psw_load_q;
  assign show       = show_q;
  assign counting   = counting_q;
  assign sec_left   = sec_left_q;
  assign tries_left = tries_left_q;
  assign round      = round_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign beep       = beep_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bomb_round_ctrl.sv
// Self-checking bench for bomb_round_ctrl: vector table for the win path, hand sequences for corner cases.
module tb_bomb_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       load = 1'b0;
  logic       enter = 1'b0;
  logic [6:0] sw = '0;
  logic [6:0] psw = '0;
  logic       psw_load, show, counting, win, lose, beep, done;
  logic [6:0] ld;
  logic [2:0] sec_left;
  logic [1:0] tries_left;
  logic [1:0] round;

  bomb_round_ctrl #(
    .PSW_W(7), .TICK_DIV(4), .SHOW_SEC(2), .CNT_SEC(5),
    .MAX_TRIES(2), .ROUNDS(2), .FACE_SEC(1), .PENALTY_SEC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .load(load), .enter(enter),
    .sw(sw), .psw(psw), .psw_load(psw_load), .show(show), .counting(counting),
    .ld(ld), .sec_left(sec_left), .tries_left(tries_left), .round(round),
    .win(win), .lose(lose), .beep(beep), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pl;
    logic       sh;
    logic       ct;
    logic [6:0] ld;
    logic [2:0] sec;
    logic [1:0] tries;
    logic [1:0] rnd;
    logic       w;
    logic       lo;
    logic       b;
    logic       d;
  } obs_t;

  typedef struct {
    logic       arm;
    logic       load;
    logic       enter;
    logic [6:0] sw;
    logic [6:0] psw;
    int         reps;
    obs_t       exp;
  } vec_t;

  logic [20:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  vec_t tbl[12];

  function automatic obs_t mk(input int pl, sh, ct, l, s, t, r, w, lo, b, d);
    obs_t o;
    o.pl = pl[0]; o.sh = sh[0]; o.ct = ct[0]; o.ld = l[6:0];
    o.sec = s[2:0]; o.tries = t[1:0]; o.rnd = r[1:0];
    o.w = w[0]; o.lo = lo[0]; o.b = b[0]; o.d = d[0];
    return o;
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.pl = psw_load; o.sh = show; o.ct = counting; o.ld = ld;
    o.sec = sec_left; o.tries = tries_left; o.rnd = round;
    o.w = win; o.lo = lose; o.b = beep; o.d = done;
    return o;
  endfunction

  task automatic compare(input string name);
    obs_t got;
    obs_t want;
    got  = actual();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s actual={pl%0b sh%0b ct%0b ld%h sec%0d tr%0d rnd%0d w%0b l%0b b%0b d%0b} required={pl%0b sh%0b ct%0b ld%h sec%0d tr%0d rnd%0d w%0b l%0b b%0b d%0b}",
               name, got.pl, got.sh, got.ct, got.ld, got.sec, got.tries, got.rnd, got.w, got.lo, got.b, got.d,
               want.pl, want.sh, want.ct, want.ld, want.sec, want.tries, want.rnd, want.w, want.lo, want.b, want.d);
    end
  endtask

  task automatic drive(input logic a, l, e, input logic [6:0] s, p);
    arm = a; load = l; enter = e; sw = s; psw = p;
  endtask

  // expected is queued when the cycle's stimulus is applied, checked #1 after the edge
  task automatic step(input string name, input obs_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    load  = 1'b0;
    enter = 1'b0;
    compare(name);
  endtask

  task automatic check_now(input string name, input obs_t e);
    exp_q.push_back(e);
    compare(name);
  endtask

  task automatic run_to_input(input logic [6:0] p);
    drive(1'b1, 1'b1, 1'b0, 7'h00, p);
    step("start_load", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("load_capture", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) step("show_phase", mk(0, 1, 0, int'(p), 0, 0, 0, 0, 0, 0, 0));
    step("input_entry", mk(0, 0, 1, 0, 5, 2, 0, 0, 0, 0, 0));
  endtask

  // cycles k=1..n after INPUT entry with no enter: one second per 4 cycles
  task automatic count_input(input int n);
    for (int k = 1; k <= n; k++) step("countdown", mk(0, 0, 1, 0, 5 - k / 4, 2, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 7'h00, 7'h55, 1, mk(1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 7'h00, 7'h55, 1, mk(0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 7'h00, 7'h55, 8, mk(0, 1, 0, 'h55,  0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 7'h00, 7'h55, 1, mk(0, 0, 1, 0,     5, 2, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 7'h55, 7'h2A, 1, mk(1, 0, 0, 0,     5, 2, 1, 0, 0, 0, 0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 7'h55, 7'h2A, 1, mk(0, 0, 0, 0,     5, 2, 1, 0, 0, 0, 0)};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 7'h55, 7'h2A, 8, mk(0, 1, 0, 'h2A,  5, 2, 1, 0, 0, 0, 0)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 7'h55, 7'h2A, 1, mk(0, 0, 1, 'h55,  5, 2, 1, 0, 0, 0, 0)};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 7'h2A, 7'h2A, 1, mk(0, 0, 0, 0,     5, 2, 1, 1, 0, 1, 0)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 7'h2A, 7'h2A, 3, mk(0, 0, 0, 0,     5, 2, 1, 1, 0, 1, 0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 7'h2A, 7'h2A, 1, mk(0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 7'h2A, 7'h2A, 1, mk(0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0)};

    // reset
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 7'h00, 7'h55);
    step("load_without_arm", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // two-round win path
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        drive(tbl[i].arm, tbl[i].load, tbl[i].enter, tbl[i].sw, tbl[i].psw);
        step($sformatf("win_row%0d", i), tbl[i].exp);
      end
    end

    // timeout in round 0
    run_to_input(7'h55);
    count_input(19);
    step("timeout_lose", mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 1, 0));
    for (int k = 0; k < 3; k++) step("timeout_hold", mk(0, 0, 0, 0, 0, 2, 0, 0, 1, 1, 0));
    step("timeout_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("timeout_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // two wrong entries right after INPUT entry
    run_to_input(7'h55);
    drive(1'b1, 1'b0, 1'b1, 7'h00, 7'h55);
`ifdef PENALTY_EN
    step("tries_first", mk(0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b1, 7'h00, 7'h55);
    step("tries_lose", mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
`else
    step("tries_first", mk(0, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b1, 7'h00, 7'h55);
    step("tries_lose", mk(0, 0, 0, 0, 5, 0, 0, 0, 1, 1, 0));
`endif
    drive(1'b0, 1'b0, 1'b0, 7'h00, 7'h55);
    step("abort_lose", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // matching enter on the timeout tick
    run_to_input(7'h55);
    count_input(19);
    drive(1'b1, 1'b0, 1'b1, 7'h55, 7'h55);
    step("same_cycle_win", mk(1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0));
    drive(1'b0, 1'b0, 1'b0, 7'h55, 7'h55);
    step("abort_load", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // arm drop mid-SHOW; enter in SHOW is ignored
    drive(1'b1, 1'b1, 1'b0, 7'h00, 7'h33);
    step("abort_start", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("abort_capture", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step("abort_show", mk(0, 1, 0, 'h33, 0, 0, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b1, 7'h33, 7'h33);
    step("enter_in_show", mk(0, 1, 0, 'h33, 0, 0, 0, 0, 0, 0, 0));
    drive(1'b0, 1'b0, 1'b0, 7'h33, 7'h33);
    step("abort_show_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("abort_no_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // penalty scenario: wrong entries starting at sec_left=3
    run_to_input(7'h55);
    count_input(8);
    drive(1'b1, 1'b0, 1'b1, 7'h00, 7'h55);
`ifdef PENALTY_EN
    step("penalty_first", mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b1, 7'h00, 7'h55);
    step("penalty_lose", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
`else
    step("nopenalty_first", mk(0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b1, 7'h00, 7'h55);
    step("nopenalty_lose", mk(0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0));
`endif
    drive(1'b0, 1'b0, 1'b0, 7'h00, 7'h55);
    step("abort_penalty", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // asynchronous reset mid-INPUT
    run_to_input(7'h2A);
    drive(1'b1, 1'b0, 1'b0, 7'h11, 7'h2A);
    step("pre_reset_input", mk(0, 0, 1, 'h11, 5, 2, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    check_now("reset_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("reset_held", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("reset_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
